quan_scale_regs_v3: RTL and testbench
=====================================

// Module: quan_scale_regs_v3
// PURPOSE
// Double-buffered per-channel E-scale register file for the quantisation stage behind the conv core.
// A loader FSM fills a shadow bank from a valid/ready word stream while the active bank serves
// per-output-row reads of SA_ROW_NUM scale sets. A tile_swap pulse promotes the full shadow bank to active,
// so the next tile's scales load with no compute stall.
// PARAMETERS
// SA_ROW_NUM     4    SA rows in conv core (channels output per read)
// ROW_NUM_IN_SA  16   rows per SA; valid read index range 1..ROW_NUM_IN_SA
// SCALE_WIDTH    8    bits per scale
// PE_PAR         2    scales per set; SET_W = SCALE_WIDTH*PE_PAR (16)
// WORD_WIDTH     512  load word width
// Derived: NUM_SETS = SA_ROW_NUM*ROW_NUM_IN_SA (64); SPW0 = WORD_WIDTH/SCALE_WIDTH (64); SPW1 = WORD_WIDTH/SET_W (32)
// Derived: NW_m = ceil(NUM_SETS/SPWm), giving NW0 = 1 and NW1 = 2
// IDX_W = $clog2(ROW_NUM_IN_SA+1)
// PORTS
// clk           in   1                 clock, all logic on posedge
// rst           in   1                 synchronous reset, active-high
// load_start    in   1                 pulse: begin filling shadow bank
// load_mode     in   1                 0: 8b scales zero-extended to SET_W; 1: packed SET_W sets
// s_word_valid  in   1                 load word valid
// s_word_ready  out  1                 load word ready
// s_word        in   WORD_WIDTH        load word; set/scale k at bits [k*W +: W]
// load_busy     out  1                 FSM in LOAD
// shadow_ready  out  1                 shadow bank completely written, awaiting swap
// tile_swap     in   1                 pulse: promote shadow bank to active
// active_valid  out  1                 active bank holds a loaded tile
// rd_en         in   1                 read request
// rd_row_idx    in   IDX_W             output SA row index, 1-based
// out_valid     out  1                 scale_sets valid this cycle
// scale_sets    out  SA_ROW_NUM*SET_W  {sa_row SA_ROW_NUM-1 .. sa_row 0}
// BEHAVIOUR
// - Reset: state=IDLE; bank_sel=0; word_cnt=0; active_valid=0; shadow_ready=0; out_valid=0; scale_sets=0;
//   s_word_ready=0; load_busy=0. Bank contents are not reset and are unreadable while active_valid=0.
// - Storage: two banks of NUM_SETS x SET_W. Set index = sa_row*ROW_NUM_IN_SA + (rd_row_idx-1).
// - FSM IDLE -> LOAD -> FULL.
//   - IDLE: load_start moves to LOAD, latches load_mode, sets word_cnt=0.
//   - LOAD: s_word_ready=1 and load_busy=1. A word is accepted when s_word_valid && s_word_ready.
//     Accepted word n writes shadow sets n*SPW .. n*SPW+SPW-1. Sets >= NUM_SETS are dropped.
//     Mode 0 writes {0, scale}; mode 1 writes the packed set.
//     Accepting word NW-1 moves to FULL, with shadow_ready=1 from the next cycle.
//     load_start in LOAD is ignored. tile_swap in LOAD is ignored.
//   - FULL: s_word_ready=0.
//     tile_swap: bank_sel flips, active_valid=1, shadow_ready=0, move to IDLE.
//     load_start without tile_swap: restart LOAD, overwriting the shadow; shadow_ready=0.
//     load_start with tile_swap in the same cycle: swap, then go directly to LOAD on the new shadow bank.
// - s_word_ready is a registered state decode and does not depend on s_word_valid.
//   No word is accepted in IDLE or FULL.
// - Read: latency 1 cycle, registered.
//   If rd_en && active_valid && 1<=rd_row_idx<=ROW_NUM_IN_SA: next cycle out_valid=1 and scale_sets =
//   concatenation of active[sa_row*ROW_NUM_IN_SA + rd_row_idx-1] for sa_row = SA_ROW_NUM-1 down to 0.
//   Otherwise out_valid=0 and scale_sets holds its previous value.
// - A read in the tile_swap cycle returns data from the pre-swap active bank.
// - Shadow writes never alter active-bank reads.
// - rst asserted mid-LOAD aborts the load. The partial shadow contents are discarded (active_valid=0).
// TESTING
// - Mode 0: load_start; one word with byte k = k+1; tile_swap; rd_row_idx=1
//   -> out_valid=1 next cycle, scale_sets = {16'h0031, 16'h0021, 16'h0011, 16'h0001}.
// - Mode 1: two words with set k = 16'h1000+k; tile_swap; rd_row_idx=16
//   -> scale_sets = {16'h103F, 16'h102F, 16'h101F, 16'h100F}. shadow_ready rises only after word 2.
// - Backpressure: valid toggled 1,0,1 in LOAD -> exactly 2 words accepted.
//   After completion, s_word_ready=0 and a third word is not accepted; the bank is unchanged.
// - Ping-pong: read active bank A (row 1 = mode-0 pattern) while loading B with all 16'hFFFF
//   -> reads stay A until tile_swap. The read issued in the swap cycle returns A; the read in the next cycle returns 16'hFFFF sets.
// - Range: rd_row_idx=0 and rd_row_idx=17, or rd_en before the first swap
//   -> out_valid=0 and scale_sets unchanged.
// - rst after 1 of 2 mode-1 words -> all outputs at reset values.
//   A new mode-0 load followed by tile_swap then behaves as in the mode-0 test.

Source files
------------

// File: rtl/quan_scale_regs_v3_if.sv
// Load-word stream bundle for the quantisation scale register file.
// The master drives valid/word and the slave returns ready.
interface quan_scale_regs_v3_if #(
  parameter int WORD_WIDTH = 512
) ();
  logic                  s_word_valid;
  logic                  s_word_ready;
  logic [WORD_WIDTH-1:0] s_word;

  modport master (output s_word_valid, output s_word, input s_word_ready);
  modport slave  (input s_word_valid, input s_word, output s_word_ready);
endinterface

// File: rtl/quan_scale_regs_v3.sv
// Double-buffered per-channel scale register file. A loader fills the shadow bank
// while the active bank serves per-row reads; tile_swap promotes the shadow bank.
module quan_scale_regs_v3 #(
  parameter int SA_ROW_NUM    = 4,
  parameter int ROW_NUM_IN_SA = 16,
  parameter int SCALE_WIDTH   = 8,
  parameter int PE_PAR        = 2,
  parameter int WORD_WIDTH    = 512,
  localparam int IDX_W        = $clog2(ROW_NUM_IN_SA + 1),
  localparam int SET_W        = SCALE_WIDTH * PE_PAR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        load_mode,
  quan_scale_regs_v3_if.slave         ld,
  output logic                        load_busy,
  output logic                        shadow_ready,
  input  logic                        tile_swap,
  output logic                        active_valid,
  input  logic                        rd_en,
  input  logic [IDX_W-1:0]            rd_row_idx,
  output logic                        out_valid,
  output logic [SA_ROW_NUM*SET_W-1:0] scale_sets
);

  localparam int NUM_SETS  = SA_ROW_NUM * ROW_NUM_IN_SA;
  localparam int SPW0      = WORD_WIDTH / SCALE_WIDTH;
  localparam int SPW1      = WORD_WIDTH / SET_W;
  localparam int NW0       = (NUM_SETS + SPW0 - 1) / SPW0;
  localparam int NW1       = (NUM_SETS + SPW1 - 1) / SPW1;
  localparam int NW_MAX    = (NW0 > NW1) ? NW0 : NW1;
  localparam int CNT_W     = $clog2(NW_MAX + 1);
  localparam int SET_IDX_W = $clog2(NUM_SETS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t                        state_r, state_s;
  logic [CNT_W-1:0]              word_cnt_r, word_cnt_s, last_cnt_s;
  logic                          mode_r, mode_s;
  logic                          bank_sel_r;
  logic                          active_valid_r;
  logic                          shadow_ready_r;
  logic                          ready_r;
  logic                          busy_r;
  logic                          out_valid_r;
  logic [SA_ROW_NUM*SET_W-1:0]   scale_sets_r;
  logic                          swap_s;
  logic                          accept_s;
  logic                          rd_hit_s;
  logic [SET_IDX_W-1:0]          rd_base_s;
  logic [SET_IDX_W-1:0]          rd_addr_s [SA_ROW_NUM];
  logic [SET_W-1:0]              bank_r [0:1][0:NUM_SETS-1];

  assign ld.s_word_ready = ready_r;
  assign load_busy       = busy_r;
  assign shadow_ready    = shadow_ready_r;
  assign active_valid    = active_valid_r;
  assign out_valid       = out_valid_r;
  assign scale_sets      = scale_sets_r;

  // Handshake qualification and per-mode word count.
  always_comb begin
    accept_s   = ld.s_word_valid && ready_r;
    last_cnt_s = mode_r ? CNT_W'(NW1 - 1) : CNT_W'(NW0 - 1);
  end

  // Loader next-state logic.
  always_comb begin
    state_s    = state_r;
    word_cnt_s = word_cnt_r;
    mode_s     = mode_r;
    swap_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_s    = ST_LOAD;
          word_cnt_s = '0;
          mode_s     = load_mode;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          word_cnt_s = word_cnt_r + CNT_W'(1);
          if (word_cnt_r == last_cnt_s) begin
            state_s = ST_FULL;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_FULL: begin
        // A swap and a restart in the same cycle chain straight into the next load.
        swap_s = tile_swap;
        if (load_start) begin
          state_s    = ST_LOAD;
          word_cnt_s = '0;
          mode_s     = load_mode;
        end else if (tile_swap) begin
          state_s    = ST_IDLE;
        end else begin
          state_s    = ST_FULL;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state and registered status decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      word_cnt_r     <= '0;
      mode_r         <= 1'b0;
      bank_sel_r     <= 1'b0;
      active_valid_r <= 1'b0;
      shadow_ready_r <= 1'b0;
      ready_r        <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      word_cnt_r     <= word_cnt_s;
      mode_r         <= mode_s;
      ready_r        <= (state_s == ST_LOAD);
      busy_r         <= (state_s == ST_LOAD);
      shadow_ready_r <= (state_s == ST_FULL);
      if (swap_s) begin
        bank_sel_r     <= ~bank_sel_r;
        active_valid_r <= 1'b1;
      end
    end
  end

  // Shadow-bank fill; sets beyond NUM_SETS in the last word are simply not stored.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        if (mode_r) begin
          if (CNT_W'(s / SPW1) == word_cnt_r) begin
            bank_r[~bank_sel_r][s] <= ld.s_word[(s % SPW1)*SET_W +: SET_W];
          end
        end else begin
          if (CNT_W'(s / SPW0) == word_cnt_r) begin
            bank_r[~bank_sel_r][s] <= {{(SET_W-SCALE_WIDTH){1'b0}},
                                       ld.s_word[(s % SPW0)*SCALE_WIDTH +: SCALE_WIDTH]};
          end
        end
      end
    end
  end

  // Read qualification and per-SA-row set addresses.
  always_comb begin
    rd_hit_s  = rd_en && active_valid_r &&
                (rd_row_idx >= IDX_W'(1)) && (rd_row_idx <= IDX_W'(ROW_NUM_IN_SA));
    rd_base_s = SET_IDX_W'(rd_row_idx - IDX_W'(1));
    for (int sa = 0; sa < SA_ROW_NUM; sa++) begin
      rd_addr_s[sa] = SET_IDX_W'(sa * ROW_NUM_IN_SA) + rd_base_s;
    end
  end

  // Registered read from the active bank; scale_sets holds on a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      scale_sets_r <= '0;
    end else if (rd_hit_s) begin
      out_valid_r <= 1'b1;
      for (int sa = 0; sa < SA_ROW_NUM; sa++) begin
        scale_sets_r[sa*SET_W +: SET_W] <= bank_r[bank_sel_r][rd_addr_s[sa]];
      end
    end else begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quan_scale_regs_v3.sv
// Directed bench for quan_scale_regs_v3: a bank/phase model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_quan_scale_regs_v3;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_mode, tile_swap, rd_en;
  logic [4:0]  rd_row_idx;
  logic        load_busy, shadow_ready, active_valid, out_valid;
  logic [63:0] scale_sets;

  quan_scale_regs_v3_if #(.WORD_WIDTH(512)) ifc ();

  quan_scale_regs_v3 dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .load_mode    (load_mode),
    .ld           (ifc),
    .load_busy    (load_busy),
    .shadow_ready (shadow_ready),
    .tile_swap    (tile_swap),
    .active_valid (active_valid),
    .rd_en        (rd_en),
    .rd_row_idx   (rd_row_idx),
    .out_valid    (out_valid),
    .scale_sets   (scale_sets)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: two banks of 64 sets, which one is active, and the loader phase.
  logic [15:0] m_bank [2][64];
  bit          m_act = 1'b0, m_av = 1'b0, m_loading = 1'b0, m_full = 1'b0, m_mode = 1'b0;
  int          m_words = 0;
  bit          exp_ov = 1'b0;
  logic [63:0] exp_sets = 64'd0;

  localparam logic [63:0] M0  = 64'h0031_0021_0011_0001;
  localparam logic [63:0] M1  = 64'h103F_102F_101F_100F;
  localparam logic [63:0] BP  = 64'h2030_2020_2010_2000;
  localparam logic [63:0] FFS = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; m_av = 1'b0; m_loading = 1'b0; m_full = 1'b0; m_words = 0;
      exp_ov = 1'b0; exp_sets = 64'd0;
    end else begin
      if (rd_en && m_av && rd_row_idx >= 5'd1 && rd_row_idx <= 5'd16) begin
        exp_ov = 1'b1;
        for (int r = 0; r < 4; r++) exp_sets[r*16 +: 16] = m_bank[m_act][r*16 + int'(rd_row_idx) - 1];
      end else begin
        exp_ov = 1'b0;
      end
      if (m_loading) begin
        if (ifc.s_word_valid) begin
          if (m_mode) begin
            for (int k = 0; k < 32; k++)
              if (m_words*32 + k < 64) m_bank[!m_act][m_words*32 + k] = ifc.s_word[k*16 +: 16];
          end else begin
            for (int k = 0; k < 64; k++)
              if (m_words*64 + k < 64) m_bank[!m_act][m_words*64 + k] = {8'h00, ifc.s_word[k*8 +: 8]};
          end
          m_words++;
          if (m_words == (m_mode ? 2 : 1)) begin
            m_loading = 1'b0;
            m_full    = 1'b1;
          end
        end
      end else if (m_full) begin
        if (tile_swap) begin
          m_act = !m_act; m_av = 1'b1; m_full = 1'b0;
        end
        if (load_start) begin
          m_full = 1'b0; m_loading = 1'b1; m_words = 0; m_mode = load_mode;
        end
      end else if (load_start) begin
        m_loading = 1'b1; m_words = 0; m_mode = load_mode;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid",    64'(out_valid),        64'(exp_ov));
      chk("scale_sets",   scale_sets,            exp_sets);
      chk("s_word_ready", 64'(ifc.s_word_ready), 64'(m_loading));
      chk("load_busy",    64'(load_busy),        64'(m_loading));
      chk("shadow_ready", 64'(shadow_ready),     64'(m_full));
      chk("active_valid", 64'(active_valid),     64'(m_av));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [511:0] w);
    ifc.s_word       = w;
    ifc.s_word_valid = 1'b1;
    tick();
    ifc.s_word_valid = 1'b0;
  endtask

  task automatic start(input logic mode);
    load_start = 1'b1;
    load_mode  = mode;
    tick();
    load_start = 1'b0;
  endtask

  task automatic swap();
    tile_swap = 1'b1;
    tick();
    tile_swap = 1'b0;
  endtask

  task automatic rd(input logic [4:0] idx);
    rd_en      = 1'b1;
    rd_row_idx = idx;
    tick();
    rd_en      = 1'b0;
  endtask

  logic [511:0] w0, w1a, w1b, bpa, bpb, dead, wff;

  initial begin
    for (int k = 0; k < 64; k++) w0[k*8 +: 8] = 8'(k + 1);
    for (int k = 0; k < 32; k++) begin
      w1a[k*16 +: 16] = 16'h1000 + 16'(k);
      w1b[k*16 +: 16] = 16'h1000 + 16'(k + 32);
      bpa[k*16 +: 16] = 16'h2000 + 16'(k);
      bpb[k*16 +: 16] = 16'h2000 + 16'(k + 32);
    end
    dead = {32{16'hDEAD}};
    wff  = {512{1'b1}};

    rst = 1'b1; load_start = 1'b0; load_mode = 1'b0; tile_swap = 1'b0;
    rd_en = 1'b0; rd_row_idx = 5'd0;
    ifc.s_word_valid = 1'b0; ifc.s_word = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_scale_sets", scale_sets, 64'd0);
    chk("rst_ready", 64'(ifc.s_word_ready), 64'd0);

    rd(5'd1);
    chk("rd_before_swap", 64'(out_valid), 64'd0);

    // Mode 0, with a swap attempt while loading that must be ignored
    start(1'b0);
    chk("m0_busy", 64'(load_busy), 64'd1);
    swap();
    chk("swap_in_load", 64'(active_valid), 64'd0);
    send(w0);
    chk("m0_shadow_ready", 64'(shadow_ready), 64'd1);
    chk("m0_ready_after", 64'(ifc.s_word_ready), 64'd0);
    swap();
    chk("m0_active_valid", 64'(active_valid), 64'd1);
    rd(5'd1);
    chk("m0_out_valid", 64'(out_valid), 64'd1);
    chk("m0_sets", scale_sets, M0);
    rd(5'd0);
    chk("idx0_valid", 64'(out_valid), 64'd0);
    chk("idx0_hold", scale_sets, M0);
    rd(5'd17);
    chk("idx17_valid", 64'(out_valid), 64'd0);
    chk("idx17_hold", scale_sets, M0);

    // Mode 1
    start(1'b1);
    send(w1a);
    chk("m1_sr_word1", 64'(shadow_ready), 64'd0);
    send(w1b);
    chk("m1_sr_word2", 64'(shadow_ready), 64'd1);
    swap();
    rd(5'd16);
    chk("m1_sets", scale_sets, M1);

    // Backpressure: valid 1,0,1 then an extra word after completion
    start(1'b1);
    send(bpa);
    tick();
    chk("bp_busy", 64'(load_busy), 64'd1);
    ifc.s_word = bpb; ifc.s_word_valid = 1'b1;
    tick();
    ifc.s_word = dead;
    tick();
    ifc.s_word_valid = 1'b0;
    chk("bp_ready_full", 64'(ifc.s_word_ready), 64'd0);
    chk("bp_sr", 64'(shadow_ready), 64'd1);
    swap();
    rd(5'd1);
    chk("bp_sets", scale_sets, BP);

    // Ping-pong: active holds the mode-0 pattern while the other bank loads all-ones
    start(1'b0);
    send(w0);
    swap();
    rd_en = 1'b1; rd_row_idx = 5'd1;
    start(1'b1);
    chk("pp_during_start", scale_sets, M0);
    send(wff);
    chk("pp_word1", scale_sets, M0);
    send(wff);
    chk("pp_word2", scale_sets, M0);
    tile_swap = 1'b1;
    tick();
    tile_swap = 1'b0;
    chk("pp_swap_cycle", scale_sets, M0);
    tick();
    chk("pp_after_swap", scale_sets, FFS);
    rd_en = 1'b0;

    // Swap and restart in the same cycle
    start(1'b1);
    send(w1a);
    send(w1b);
    tile_swap = 1'b1; load_start = 1'b1; load_mode = 1'b0;
    tick();
    tile_swap = 1'b0; load_start = 1'b0;
    chk("sl_busy", 64'(load_busy), 64'd1);
    chk("sl_sr", 64'(shadow_ready), 64'd0);
    rd(5'd16);
    chk("sl_sets", scale_sets, M1);
    send(w0);
    swap();
    rd(5'd1);
    chk("sl_m0_sets", scale_sets, M0);

    // Reset in the middle of a mode-1 load
    start(1'b1);
    send(w1a);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_sets", scale_sets, 64'd0);
    chk("mid_rst_av", 64'(active_valid), 64'd0);
    chk("mid_rst_busy", 64'(load_busy), 64'd0);
    chk("mid_rst_sr", 64'(shadow_ready), 64'd0);
    start(1'b0);
    send(w0);
    swap();
    rd(5'd1);
    chk("post_rst_ov", 64'(out_valid), 64'd1);
    chk("post_rst_sets", scale_sets, M0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
